// File: rtl/batch_sequencer_pkg.sv
// rtl/batch_sequencer_pkg.sv - transpose-conv shared types and layer D1 constants
package batch_sequencer_pkg;

  // Batch-loop FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_REQ   = 3'd1,
    ST_LOAD_WAIT  = 3'd2,
    ST_SCHED_GO   = 3'd3,
    ST_SCHED_WAIT = 3'd4,
    ST_ADVANCE    = 3'd5,
    ST_FINISH     = 3'd6
  } seq_state_t;

  // Layer D1: 256 rows x 512 cols, 32 tiles split into 8 weight batches of 4 tiles
  localparam int D1_NUM_BATCHES      = 8;
  localparam int D1_TILES_PER_BATCH  = 4;
  localparam int D1_PASSES_PER_BATCH = 128;

  // Width of the per-wait-state watchdog counter
  localparam int WDOG_W = 21;

endpackage

// File: rtl/batch_sequencer.sv
// rtl/batch_sequencer.sv - weight-reload batch loop in front of the transpose-conv tile scheduler (optional watchdog: BATCH_SEQ_WATCHDOG_EN)
module batch_sequencer
  import batch_sequencer_pkg::*;
#(
  parameter int NUM_BATCHES = D1_NUM_BATCHES,
  parameter int BATCH_W     = 3
`ifdef BATCH_SEQ_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 1048576
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_layer,
  input  logic               abort,
  output logic               wt_load_req,
  output logic [BATCH_W-1:0] wt_batch_id,
  input  logic               wt_load_done,
  output logic               sched_start,
  output logic [BATCH_W-1:0] sched_batch_id,
  input  logic               sched_done,
  input  logic               sched_batch_complete,
  output logic               busy,
  output logic [BATCH_W:0]   batches_done,
  output logic               layer_done,
  output logic               seq_err
`ifdef BATCH_SEQ_WATCHDOG_EN
  ,
  output logic               wdog_trip
`endif
);

  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCHES - 1);

  seq_state_t         state, state_nxt;
  logic [BATCH_W-1:0] batch_cnt, cnt_nxt;
  logic [BATCH_W:0]   done_nxt;
  logic               err_nxt;
  logic               stop;

`ifdef BATCH_SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              in_wait;
  logic              wdog_fire;

  assign in_wait   = (state == ST_LOAD_WAIT) || (state == ST_SCHED_WAIT);
  assign wdog_fire = in_wait && (wdog_cnt == WDOG_LAST);
  assign stop      = abort | wdog_fire;

  // Watchdog counts cycles spent in one wait state; any state change restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= wdog_fire;
      if (state_nxt != state || !in_wait) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
    end
  end
`else
  assign stop = abort;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next batch counter/count and error flag; abort (or watchdog) overrides every transition
  always_comb begin
    state_nxt = state;
    cnt_nxt   = batch_cnt;
    done_nxt  = batches_done;
    err_nxt   = seq_err;

    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_layer) begin
            state_nxt = ST_LOAD_REQ;
            cnt_nxt   = '0;
            done_nxt  = '0;
            err_nxt   = 1'b0;
          end
        end
        ST_LOAD_REQ:  state_nxt = ST_LOAD_WAIT;
        ST_LOAD_WAIT: begin
          if (wt_load_done) begin
            state_nxt = ST_SCHED_GO;
          end
        end
        ST_SCHED_GO:  state_nxt = ST_SCHED_WAIT;
        ST_SCHED_WAIT: begin
          if (sched_done) begin
            state_nxt = ST_ADVANCE;
            done_nxt  = batches_done + (BATCH_W+1)'(1);
          end
        end
        ST_ADVANCE: begin
          // Compare before incrementing so the counter never wraps
          if (batch_cnt == LAST_BATCH) begin
            state_nxt = ST_FINISH;
          end else begin
            cnt_nxt   = batch_cnt + BATCH_W'(1);
            state_nxt = ST_LOAD_REQ;
          end
        end
        ST_FINISH:    state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end

    // Protocol errors are sticky; stray pulses are otherwise ignored
    if (state == ST_SCHED_WAIT && (sched_done != sched_batch_complete)) begin
      err_nxt = 1'b1;
    end
    if (wt_load_done && state != ST_LOAD_WAIT) begin
      err_nxt = 1'b1;
    end
    if (sched_done && state != ST_SCHED_WAIT) begin
      err_nxt = 1'b1;
    end
`ifdef BATCH_SEQ_WATCHDOG_EN
    if (wdog_fire) begin
      err_nxt = 1'b1;
    end
`endif
  end

  // Registered outputs decoded from the next state so each appears on the edge that enters its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_cnt      <= '0;
      wt_load_req    <= 1'b0;
      wt_batch_id    <= '0;
      sched_start    <= 1'b0;
      sched_batch_id <= '0;
      busy           <= 1'b0;
      batches_done   <= '0;
      layer_done     <= 1'b0;
      seq_err        <= 1'b0;
    end else begin
      batch_cnt    <= cnt_nxt;
      wt_load_req  <= (state_nxt == ST_LOAD_REQ) || (state_nxt == ST_LOAD_WAIT);
      sched_start  <= (state_nxt == ST_SCHED_GO);
      busy         <= (state_nxt != ST_IDLE);
      batches_done <= done_nxt;
      layer_done   <= (state_nxt == ST_FINISH);
      seq_err      <= err_nxt;
      // Batch id is loaded with the reload request and held through the scheduler run
      if (state_nxt == ST_LOAD_REQ) begin
        wt_batch_id    <= cnt_nxt;
        sched_batch_id <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_batch_sequencer.sv
// tb/tb_batch_sequencer.sv - randomized directed bench for batch_sequencer
module tb_batch_sequencer;

  localparam int N  = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_layer;
  logic          abort;
  logic          wt_load_req;
  logic [BW-1:0] wt_batch_id;
  logic          wt_load_done;
  logic          sched_start;
  logic [BW-1:0] sched_batch_id;
  logic          sched_done;
  logic          sched_batch_complete;
  logic          busy;
  logic [BW:0]   batches_done;
  logic          layer_done;
  logic          seq_err;

  int errors = 0;
  int checks = 0;
  int req_ids[$];
  int start_ids[$];
  int layer_cnt = 0;
  logic req_q = 1'b0;
  logic err_exp = 1'b0;

  batch_sequencer #(.NUM_BATCHES(N), .BATCH_W(BW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start_layer          (start_layer),
    .abort                (abort),
    .wt_load_req          (wt_load_req),
    .wt_batch_id          (wt_batch_id),
    .wt_load_done         (wt_load_done),
    .sched_start          (sched_start),
    .sched_batch_id       (sched_batch_id),
    .sched_done           (sched_done),
    .sched_batch_complete (sched_batch_complete),
    .busy                 (busy),
    .batches_done         (batches_done),
    .layer_done           (layer_done),
    .seq_err              (seq_err)
  );

  always #5 clk = ~clk;

  // Event recorder: reload requests, scheduler starts and layer completions
  always @(negedge clk) begin
    if (rst_n) begin
      if (wt_load_req && !req_q) req_ids.push_back(int'(wt_batch_id));
      if (sched_start) start_ids.push_back(int'(sched_batch_id));
      if (layer_done) layer_cnt++;
    end
    req_q = wt_load_req;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    req_ids.delete();
    start_ids.delete();
    layer_cnt = 0;
  endtask

  // One layer run against an ideal loader/scheduler with random latencies.
  // abort_b: batch aborted in SCHED_WAIT; nocmp_b: batch whose done lacks batch_complete;
  // restart_b: batch during which a redundant start_layer is pulsed. -1 disables each.
  task automatic run_layer(input int abort_b, input int nocmp_b, input int restart_b);
    int to;
    int d;
    clear_log();
    start_layer = 1'b1;
    step();
    start_layer = 1'b0;
    err_exp = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_req_latency", 32'(wt_load_req), 32'd1);
    chk("start_err_clear", 32'(seq_err), 32'd0);
    chk("start_done_clear", 32'(batches_done), 32'd0);
    for (int b = 0; b < N; b++) begin
      to = 0;
      while (!wt_load_req && to < 50) begin
        step();
        to++;
      end
      chk("req_seen", 32'(wt_load_req), 32'd1);
      chk("req_id", 32'(wt_batch_id), 32'(b));
      d = $urandom_range(1, 6);
      repeat (d) step();
      chk("req_hold", 32'(wt_load_req), 32'd1);
      chk("no_early_start", 32'(sched_start), 32'd0);
      if (b == restart_b) begin
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        chk("restart_ignored_busy", 32'(busy), 32'd1);
        chk("restart_ignored_req", 32'(wt_load_req), 32'd1);
      end
      wt_load_done = 1'b1;
      step();
      wt_load_done = 1'b0;
      chk("sched_start", 32'(sched_start), 32'd1);
      chk("sched_id", 32'(sched_batch_id), 32'(b));
      chk("req_drop", 32'(wt_load_req), 32'd0);
      d = $urandom_range(2, 20);
      for (int k = 0; k < d; k++) begin
        step();
        chk("sched_pulse_once", 32'(sched_start), 32'd0);
        chk("sched_id_stable", 32'(sched_batch_id), 32'(b));
      end
      if (b == abort_b) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(wt_load_req), 32'd0);
        chk("abort_batches_done", 32'(batches_done), 32'(b));
        repeat (5) step();
        chk("abort_no_layer_done", 32'(layer_cnt), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        return;
      end
      sched_done = 1'b1;
      sched_batch_complete = (b != nocmp_b);
      step();
      sched_done = 1'b0;
      sched_batch_complete = 1'b0;
      if (b == nocmp_b) err_exp = 1'b1;
      chk("batches_done", 32'(batches_done), 32'(b + 1));
      chk("seq_err", 32'(seq_err), 32'(err_exp));
      if (b == N - 1) begin
        chk("layer_done_not_early", 32'(layer_done), 32'd0);
        step();
        chk("layer_done_latency", 32'(layer_done), 32'd1);
        chk("finish_busy", 32'(busy), 32'd1);
      end
    end
    step();
    chk("layer_done_single", 32'(layer_done), 32'd0);
    chk("end_idle", 32'(busy), 32'd0);
    chk("end_batches_done", 32'(batches_done), 32'(N));
    chk("end_seq_err", 32'(seq_err), 32'(err_exp));
    chk("layer_done_count", 32'(layer_cnt), 32'd1);
    chk("req_count", 32'(req_ids.size()), 32'(N));
    chk("start_count", 32'(start_ids.size()), 32'(N));
    for (int i = 0; i < N && i < req_ids.size() && i < start_ids.size(); i++) begin
      chk("req_order", 32'(req_ids[i]), 32'(i));
      chk("start_order", 32'(start_ids[i]), 32'(i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_layer = 1'b0;
    abort = 1'b0;
    wt_load_done = 1'b0;
    sched_done = 1'b0;
    sched_batch_complete = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(wt_load_req), 32'd0);
    chk("rst_outputs", 32'({wt_batch_id, sched_start, sched_batch_id, layer_done, seq_err}), 32'd0);
    chk("rst_batches_done", 32'(batches_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_req", 32'(wt_load_req), 32'd0);

    // Stray wt_load_done in IDLE
    clear_log();
    wt_load_done = 1'b1;
    step();
    wt_load_done = 1'b0;
    chk("stray_load_err", 32'(seq_err), 32'd1);
    repeat (4) step();
    chk("stray_load_idle", 32'(busy), 32'd0);
    chk("stray_load_no_start", 32'(start_ids.size()), 32'd0);
    chk("stray_load_err_sticky", 32'(seq_err), 32'd1);

    // Clean run, redundant start mid-run, missing batch_complete, abort, clean rerun
    run_layer(-1, -1, -1);
    run_layer(-1, -1, 3);
    run_layer(-1, 2, -1);
    run_layer(5, -1, -1);
    run_layer(-1, -1, -1);

    // Abort coincident with start_layer in IDLE keeps the block idle and the count
    abort = 1'b1;
    start_layer = 1'b1;
    step();
    abort = 1'b0;
    start_layer = 1'b0;
    chk("abort_start_idle", 32'(busy), 32'd0);
    chk("abort_start_req", 32'(wt_load_req), 32'd0);
    chk("abort_start_keep_done", 32'(batches_done), 32'(N));
    repeat (3) step();
    chk("abort_start_still_idle", 32'(busy), 32'd0);

    // Stray sched_done in IDLE
    clear_log();
    sched_done = 1'b1;
    step();
    sched_done = 1'b0;
    chk("stray_done_err", 32'(seq_err), 32'd1);
    repeat (3) step();
    chk("stray_done_idle", 32'(busy), 32'd0);
    chk("stray_done_no_layer_done", 32'(layer_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/batch_sequencer.md
Name: batch_sequencer

Overview:
- Sits directly upstream of the transpose-conv tile scheduler for layer D1 (256 rows × 512 cols, 32 tiles, 8 batches of 4 tiles).
- Owns the batch loop:
  - requests a weight-BRAM reload for the current batch;
  - starts the scheduler and waits for it to finish;
  - advances batch_id, then repeats until all batches are done.
- Signals layer completion to the top-level controller.

Parameters:
- NUM_BATCHES, 8, number of weight-reload batches per layer (1..2^BATCH_W).
- BATCH_W, 3, width of the batch id.
- WDOG_CYCLES, 1048576, watchdog limit in cycles per wait state (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_layer  in  1  single-cycle pulse that starts a layer run
- abort  in  1  synchronous abort; returns the block to IDLE
- wt_load_req  out  1  level; weight reload request for wt_batch_id
- wt_batch_id  out  BATCH_W  batch whose weights must be loaded
- wt_load_done  in  1  single-cycle pulse; weight BRAM is loaded
- sched_start  out  1  single-cycle pulse to the scheduler's start input
- sched_batch_id  out  BATCH_W  drives the scheduler's current_batch_id
- sched_done  in  1  scheduler done pulse
- sched_batch_complete  in  1  scheduler batch_complete pulse
- busy  out  1  high in every state except IDLE
- batches_done  out  BATCH_W+1  count of completed batches in this run
- layer_done  out  1  single-cycle pulse when the last batch finishes
- seq_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; batch counter 0. All outputs are registered.
- States: IDLE, LOAD_REQ, LOAD_WAIT, SCHED_GO, SCHED_WAIT, ADVANCE, FINISH.
- IDLE:
  - On start_layer: clear batch counter, batches_done and seq_err; go to LOAD_REQ.
  - start_layer while busy is ignored.
- LOAD_REQ: assert wt_load_req, set wt_batch_id = batch counter; go to LOAD_WAIT.
- LOAD_WAIT:
  - Hold wt_load_req high.
  - On wt_load_done: drop wt_load_req on the next edge and go to SCHED_GO.
- SCHED_GO:
  - Pulse sched_start for exactly 1 cycle.
  - sched_batch_id equals the batch counter and stays stable from one cycle before the pulse until sched_done.
  - Go to SCHED_WAIT.
- SCHED_WAIT:
  - On sched_done go to ADVANCE.
  - sched_batch_complete is expected in the same cycle as sched_done.
  - If sched_done arrives without sched_batch_complete, or sched_batch_complete arrives alone, set seq_err. The sequence continues on sched_done.
- ADVANCE:
  - Increment batches_done.
  - If the batch counter equals NUM_BATCHES-1, go to FINISH.
  - Otherwise increment the batch counter and go to LOAD_REQ.
  - This guarantees at least one idle cycle between sched_done and the next sched_start, so the scheduler is back in IDLE.
- FINISH: pulse layer_done for 1 cycle; go to IDLE. batches_done holds NUM_BATCHES until the next start_layer.
- Minimum latency:
  - start_layer to first wt_load_req: 1 cycle.
  - wt_load_done to sched_start: 1 cycle.
  - sched_done on the last batch to layer_done: 2 cycles.
- Stray pulses:
  - wt_load_done outside LOAD_WAIT: ignored, sets seq_err.
  - sched_done outside SCHED_WAIT: ignored, sets seq_err.
- abort:
  - Has priority over every transition. Next state is IDLE.
  - Drops wt_load_req, does not pulse layer_done, and keeps batches_done.
  - An abort coincident with start_layer in IDLE stays in IDLE.
- Batch counter never wraps; it is compared against NUM_BATCHES-1 before incrementing.

Optional Feature:
- Macro: BATCH_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A 21-bit counter runs in LOAD_WAIT and SCHED_WAIT and clears on every state change.
  - Reaching WDOG_CYCLES sets seq_err and forces IDLE, with the same effect as abort.
  - An extra output port wdog_trip (1 bit) pulses for 1 cycle when the watchdog fires.
- Without the macro: no counter, no wdog_trip port, and the block waits indefinitely.

Decomposition:
- Shared package (transpose-conv package):
  - state encoding constants;
  - D1_NUM_BATCHES = 8, D1_TILES_PER_BATCH = 4, D1_PASSES_PER_BATCH = 128.
- No sub-module; the watchdog is an inline counter under the macro.

Test Plan:
- Full run with an ideal scheduler model (done after 20 cycles) and wt_load_done 5 cycles after each req:
  - 8 wt_load_req with wt_batch_id 0..7;
  - 8 sched_start pulses with sched_batch_id 0..7;
  - layer_done once, 2 cycles after the 8th sched_done;
  - batches_done = 8, seq_err = 0.
- start_layer pulsed again during batch 3 -> ignored; batch sequence unchanged; layer_done still after batch 7.
- abort asserted in SCHED_WAIT of batch 5 -> IDLE next cycle; wt_load_req = 0; no layer_done; batches_done = 5. A following start_layer restarts at batch 0.
- sched_done without sched_batch_complete on batch 2 -> seq_err = 1 (sticky); run completes with layer_done; seq_err clears on the next start_layer.
- Stray wt_load_done in IDLE -> seq_err = 1; state stays IDLE; no sched_start.
- With BATCH_SEQ_WATCHDOG_EN and WDOG_CYCLES = 100, wt_load_done never sent -> wdog_trip pulses after 100 cycles in LOAD_WAIT; seq_err = 1; busy = 0.
